// File: rtl/pf_fetch.sv
// Playfield line fetcher. Reads one character row of tile codes from the playfield
// RAM into a ping-pong pair of 32-byte line buffers and serves tile codes by column.
module pf_fetch #(
  parameter int ROWS = 30,
  parameter int WPR  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [4:0]  row,
  input  logic        flip,
  input  logic [4:0]  col,
  output logic [7:0]  addr_b,
  output logic [3:0]  ce_b,
  input  logic [31:0] dout_b,
  output logic [7:0]  tile_code,
  output logic        busy,
  output logic        overrun
);

  localparam int WW = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int NB = 4 * WPR;
  localparam logic [WW-1:0] W_LAST = WW'(WPR - 1);
  localparam logic [5:0]    ROWS_L = 6'(ROWS);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   w_q, w_d;
  logic [4:0]      r_q, r_d;
  logic [7:0]      addr_q, addr_d;
  logic [3:0]      ce_q, ce_d;
  logic            cap_en_q, cap_en_d;
  logic            cap_zero_q, cap_zero_d;
  logic [WW-1:0]   cap_w_q, cap_w_d;
  logic            fill_q, fill_d;
  logic            ovr_q, ovr_d;
  logic [7:0]      tile_q, tile_d;
  logic [7:0]      buf_q [2][NB];
  logic [7:0]      buf_d [2][NB];

  logic [4:0]      r_eff;
  logic [15:0]     addr_full;
  logic [4:0]      rd_idx;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; any line_start (re)starts the fetch at word 0
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (line_start) state_d = FETCH;
      FETCH:   if (line_start) state_d = FETCH;
               else if (w_q == W_LAST) state_d = DRAIN;
      DRAIN:   state_d = line_start ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != IDLE);
  end

  assign r_eff = flip ? (5'(ROWS - 1) - row) : row;

  // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    w_d = w_q;
    r_d = r_q;
    if (line_start) begin
      w_d = '0;
      r_d = r_eff;
    end else if (state_q == FETCH) begin
      w_d = (w_q == W_LAST) ? '0 : w_q + WW'(1);
    end

    // RAM address/enables are registered from next-state values so they are glitch-free
    addr_full = 16'(r_d) * 16'(WPR) + 16'(w_d);
    addr_d    = (state_d == FETCH) ? addr_full[7:0] : addr_q;
    ce_d      = ((state_d == FETCH) && ({1'b0, r_d} < ROWS_L)) ? 4'b0000 : 4'b1111;

    // Read data lags the address by one cycle; remember which word is in flight
    cap_en_d   = (state_q == FETCH);
    cap_w_d    = w_q;
    cap_zero_d = !({1'b0, r_q} < ROWS_L);

    ovr_d  = ovr_q | (line_start & busy);
    fill_d = (line_start && !busy) ? ~fill_q : fill_q;

    buf_d = buf_q;
    if (cap_en_q) begin
      for (int k = 0; k < 4; k++) begin
        buf_d[fill_q][{cap_w_q, 2'(k)}] = cap_zero_q ? 8'h00 : dout_b[8*k +: 8];
      end
    end

    // Read from the bank that is on display after this cycle's swap
    rd_idx = flip ? ~col : col;
    tile_d = buf_q[~fill_d][rd_idx];
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_q        <= '0;
      r_q        <= '0;
      addr_q     <= '0;
      ce_q       <= 4'b1111;
      cap_en_q   <= 1'b0;
      cap_zero_q <= 1'b0;
      cap_w_q    <= '0;
      fill_q     <= 1'b0;
      ovr_q      <= 1'b0;
      tile_q     <= '0;
      // NOTE: the line buffers are cleared on reset so a blank line shows before the first fetch.
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NB; i++) buf_q[b][i] <= 8'h00;
      end
    end else begin
      w_q        <= w_d;
      r_q        <= r_d;
      addr_q     <= addr_d;
      ce_q       <= ce_d;
      cap_en_q   <= cap_en_d;
      cap_zero_q <= cap_zero_d;
      cap_w_q    <= cap_w_d;
      fill_q     <= fill_d;
      ovr_q      <= ovr_d;
      tile_q     <= tile_d;
      buf_q      <= buf_d;
    end
  end

  assign addr_b    = addr_q;
  assign ce_b      = ce_q;
  assign tile_code = tile_q;
  assign overrun   = ovr_q;

endmodule

// File: doc/pf_fetch.md
PF_FETCH -- requirements
Module: pf_fetch

Interface
REQ-001 Parameter ROWS, default 30: number of valid playfield character rows.
REQ-002 Parameter WPR, default 8: 32-bit playfield words per row (4 tile bytes per word, 32 columns).
REQ-003 clk  in  1  system clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 line_start  in  1  one-cycle pulse: begin fetch of next line, swap buffers.
REQ-006 row  in  5  character row to fetch on line_start.
REQ-007 flip  in  1  screen flip; sampled on line_start for row, used live for column.
REQ-008 col  in  5  display column to read out.
REQ-009 addr_b  out  8  playfield RAM read-port word address.
REQ-010 ce_b  out  4  playfield RAM read-port lane enables, active low.
REQ-011 dout_b  in  32  playfield RAM read data, lanes {col3,col2,col1,col0}.
REQ-012 tile_code  out  8  tile code for col, from display buffer.
REQ-013 busy  out  1  fetch in progress.
REQ-014 overrun  out  1  sticky: line_start arrived while busy.

Function
REQ-015 Two 32-byte line buffers, ping-pong: fill bank (written by fetch) and display bank (read by col).
REQ-016 FSM states IDLE, FETCH, DRAIN; IDLE -> FETCH on line_start; FETCH after WPR addresses -> DRAIN; DRAIN -> IDLE after one cycle.
REQ-017 Effective row r = flip ? ROWS-1-row : row, latched on line_start.
REQ-018 In FETCH, word index w counts 0..WPR-1, one per cycle; addr_b = r*WPR + w (8-bit, truncated); ce_b = 4'b0000.
REQ-019 dout_b for address issued in cycle n is captured in cycle n+1 into fill bank bytes 4w..4w+3 (lane k -> byte 4w+k).
REQ-020 Total fetch: WPR+1 cycles from first FETCH cycle to last buffer write (DRAIN cycle); busy high in FETCH and DRAIN.
REQ-021 ce_b = 4'b1111 and addr_b holds last value outside FETCH.
REQ-022 If latched r >= ROWS: no RAM access (ce_b = 4'b1111 throughout), fill bank bytes all written 0, same state sequence and timing.
REQ-023 On line_start with busy low: display bank <- previous fill bank, fill bank <- previous display bank, fetch starts next cycle.
REQ-024 On line_start with busy high: overrun <- 1, no bank swap, fetch restarts at w=0 into same fill bank with newly latched row.
REQ-025 tile_code registered, 1-cycle latency: tile_code <= display_bank[flip ? 31-col : col] every cycle.
REQ-026 Swap and readout in same cycle: tile_code in the cycle after line_start reflects the new display bank.
REQ-027 overrun cleared only by reset.

Reset
REQ-028 On reset: state IDLE, busy 0, overrun 0, tile_code 0, addr_b 0, ce_b 4'b1111, w 0.
REQ-029 On reset: fill bank = bank 0, display bank = bank 1, all 64 buffer bytes cleared to 0.
REQ-030 Reset mid-fetch aborts immediately; no further buffer writes.

Verification
REQ-031 RAM word (r*8+w) = {r,w,2'b11,r,w,2'b00}-style pattern; line_start row=3 flip=0 -> addr_b 24..31 on 8 consecutive cycles, busy 9 cycles; second line_start then col=5 -> tile_code equals lane 1 of word 25 one cycle later.
REQ-032 flip=1, row=0 on line_start -> addr_b 232..239 (row 29); after swap col=0 -> byte 31 of fetched line.
REQ-033 row=30 -> ce_b stays 4'b1111, after swap every col returns tile_code 0.
REQ-034 Second line_start 4 cycles after first -> overrun=1, no swap (tile_code unchanged), addr_b restarts at new row base.
REQ-035 Assert reset during FETCH cycle 5 -> next cycle busy 0, ce_b 4'b1111, tile_code 0, all cols read 0.
